sram_responder: RTL

Cycle-accurate responder for the off-chip 16-bit asynchronous SRAM port driven by the MEM stage's SRAM controller. It sits on the testbench or board-model side of `sramData` / `sramAddress` / `sramCtrl` and stores data into a word array. It returns read data after a programmable number of stable-address cycles. It also flags protocol violations and counts completed accesses, so the cache/SRAM path can be verified against real-device timing.

---
 rtl/sram_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// sram_responder: cycle-accurate 16-bit asynchronous SRAM device model with
// programmable read/write latency, protocol-violation flag and access counters.
module sram_responder #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic              err,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam int LANE_W  = DATA_W / 2;
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_VALID
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LAT_W-1:0]  lat;
    logic              done;
    logic [DATA_W-1:0] dq_q;
    logic [1:0]        lane_oe;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              strobe;
    logic              rd_req;
    logic              same;
    logic              held;
    logic              pending;
    logic [LAT_W-1:0]  w_lat;
    logic [LAT_W-1:0]  r_lat;
    logic              commit;
    logic              stay_valid;
    logic              go_valid;
    logic              rd_done;
    logic              err_set;
    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;

    // held: this strobe already committed, so a long strobe writes only once
    always_comb begin
        strobe     = !SRAM_CE_N && !SRAM_WE_N;
        rd_req     = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
        same       = SRAM_ADDR == addr_q;
        held       = (state == WRITE) && done;
        pending    = (state == WRITE) && !done;
        w_lat      = (state == WRITE && same) ? lat + LAT_W'(1) : LAT_W'(1);
        r_lat      = (state == READ_WAIT && same) ? lat + LAT_W'(1) : LAT_W'(1);
        commit     = !rst && strobe && !held && (w_lat == LAT_W'(WRITE_LAT));
        stay_valid = (state == READ_VALID) && same;
        go_valid   = stay_valid || (r_lat >= LAT_W'(READ_LAT));
        rd_done    = rd_req && !stay_valid && go_valid;
        err_set    = (strobe && SRAM_UB_N && SRAM_LB_N)
                   || (pending && (!strobe || !same));
        mem_word   = mem[SRAM_ADDR];
        wr_word    = {
            SRAM_UB_N ? mem_word[DATA_W-1:LANE_W] : SRAM_DQ[DATA_W-1:LANE_W],
            SRAM_LB_N ? mem_word[LANE_W-1:0]      : SRAM_DQ[LANE_W-1:0]
        };
        rd_word    = commit ? wr_word : mem_word;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[SRAM_ADDR] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            lat      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_count <= 16'd0;
            rd_count <= 16'd0;
            dq_q     <= '0;
            lane_oe  <= 2'b00;
        end else begin
            addr_q <= SRAM_ADDR;
            if (err_set) begin
                err <= 1'b1;
            end
            if (commit) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rd_done) begin
                rd_count <= rd_count + 16'd1;
            end
            unique case (1'b1)
                strobe: begin
                    state   <= WRITE;
                    done    <= held || commit;
                    lane_oe <= 2'b00;
                    if (!held) begin
                        lat <= w_lat;
                    end
                end
                rd_req: begin
                    done <= 1'b0;
                    lat  <= r_lat;
                    if (go_valid) begin
                        state   <= READ_VALID;
                        dq_q    <= rd_word;
                        lane_oe <= {!SRAM_UB_N, !SRAM_LB_N};
                    end else begin
                        // bus is driven but not yet meaningful
                        state   <= READ_WAIT;
                        dq_q    <= 'x;
                        lane_oe <= 2'b11;
                    end
                end
                default: begin
                    state   <= IDLE;
                    lat     <= '0;
                    done    <= 1'b0;
                    lane_oe <= 2'b00;
                end
            endcase
        end
    end

    assign SRAM_DQ[DATA_W-1:LANE_W] =
        lane_oe[1] ? dq_q[DATA_W-1:LANE_W] : {LANE_W{1'bz}};
    assign SRAM_DQ[LANE_W-1:0] =
        lane_oe[0] ? dq_q[LANE_W-1:0] : {LANE_W{1'bz}};

endmodule
